// File: rtl/secuenciador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : secuenciador_pkg
//  Description : Shared types and constants for the instruction-fetch
//                sequencer: FSM state encoding, PC increment, default
//                vectors and the timeout-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package secuenciador_pkg;

    // Fetch sequencer states, 2-bit explicit encoding
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        ERROR = 2'd3
    } estado_t;

    // Byte distance between consecutive instruction words
    localparam logic [31:0] PC_INC = 32'd4;

    // Default reset and exception vectors (both word-aligned)
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

    // Width needed to count 0 .. timeout-1; never narrower than one bit
    function automatic int anchoContador(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage : secuenciador_pkg
`default_nettype wire

// File: rtl/secuenciador_pc_calc_siguiente_pc.sv
`default_nettype none
// ============================================================================
//  Module      : calc_siguiente_pc
//  Description : Combinational next-PC selection for the fetch sequencer.
//                Priority: exception (optional) > jump > taken branch >
//                sequential. All arithmetic wraps modulo 2^32.
//                Exception input and vector exist only when the macro
//                SECUENCIADOR_EXCEPCION_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_siguiente_pc
    import secuenciador_pkg::*;
`ifdef SECUENCIADOR_EXCEPCION_EN
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
)
`endif
(
    input  logic [31:0] pc,
    input  logic        salto_cond,
    input  logic        zero,
    input  logic [31:0] ext_signo,
    input  logic        salto_incond,
    input  logic [25:0] dest_salto,
`ifdef SECUENCIADOR_EXCEPCION_EN
    input  logic        excepcion,
`endif
    output logic [31:0] next_pc
);

    logic [31:0] w_pc4;
    logic [31:0] w_offset;

    // Offset is in words; the two top bits of ext_signo fall off the shift
    assign w_pc4    = pc + PC_INC;
    assign w_offset = ext_signo << 2;

    // Prioritised next-PC mux
    always_comb begin
        next_pc = w_pc4;
`ifdef SECUENCIADOR_EXCEPCION_EN
        if (excepcion)
            next_pc = EXC_VECTOR;
        else
`endif
        if (salto_incond)
            next_pc = {w_pc4[31:28], dest_salto, 2'b00};
        else if (salto_cond && zero)
            next_pc = w_pc4 + w_offset;
        else
            next_pc = w_pc4;
    end

endmodule : calc_siguiente_pc
`default_nettype wire

// File: rtl/secuenciador_pc.sv
`default_nettype none
// ============================================================================
//  Module      : secuenciador_pc
//  Description : Instruction-fetch sequencer. Owns the PC, fetches each word
//                over a req/ack handshake with a fetch timeout, issues it to
//                the datapath as a one-cycle valid pulse, then waits for
//                exec_done before moving to the next PC.
//                Optional exception support: SECUENCIADOR_EXCEPCION_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_pc
    import secuenciador_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = DEF_RESET_VECTOR,
`ifdef SECUENCIADOR_EXCEPCION_EN
    parameter logic [31:0] EXC_VECTOR    = DEF_EXC_VECTOR,
`endif
    parameter int          FETCH_TIMEOUT = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        salto_cond,
    input  logic        zero,
    input  logic [31:0] ext_signo,
    input  logic        salto_incond,
    input  logic [25:0] dest_salto,
    output logic [31:0] pc,
`ifdef SECUENCIADOR_EXCEPCION_EN
    input  logic        excepcion,
    output logic [31:0] epc,
`endif
    output logic        fetch_err
);

    localparam int                c_CNT_W      = anchoContador(FETCH_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(FETCH_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // Elaboration-time guard on the timeout range
    generate
        if (FETCH_TIMEOUT < 2 || FETCH_TIMEOUT > 255) begin : g_timeoutRangeErr
            $error("secuenciador_pc: FETCH_TIMEOUT must be in 2..255");
        end
    endgenerate

    estado_t              r_state;
    estado_t              w_stateNext;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cntNext;
    logic                 r_started;
    logic [31:0]          r_pc;
    logic [31:0]          r_instr;
    logic [31:0]          w_nextPc;
    logic                 w_loadInstr;
    logic                 w_loadPc;
`ifdef SECUENCIADOR_EXCEPCION_EN
    logic [31:0]          r_epc;
`endif

    // Next-PC datapath
    calc_siguiente_pc
`ifdef SECUENCIADOR_EXCEPCION_EN
    #(
        .EXC_VECTOR   (EXC_VECTOR)
    )
`endif
    u_calcSiguientePc (
        .pc           (r_pc),
        .salto_cond   (salto_cond),
        .zero         (zero),
        .ext_signo    (ext_signo),
        .salto_incond (salto_incond),
        .dest_salto   (dest_salto),
`ifdef SECUENCIADOR_EXCEPCION_EN
        .excepcion    (excepcion),
`endif
        .next_pc      (w_nextPc)
    );

    // State, timeout counter and the post-reset start flag.
    // r_started keeps imem_req low while rst_n is held and makes the first
    // REQ cycle after release a real, counted request cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= REQ;
            r_cnt     <= '0;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_started <= 1'b1;
        end
    end

    // Next-state, counter and load-enable decode
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_loadInstr = 1'b0;
        w_loadPc    = 1'b0;
        case (r_state)
            REQ: begin
                if (r_started) begin
                    if (imem_ack) begin
                        w_loadInstr = 1'b1;
                        w_cntNext   = '0;
                        w_stateNext = ISSUE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_stateNext = ERROR;
                    end else begin
                        w_cntNext   = r_cnt + c_CNT_ONE;
                    end
                end
            end
            ISSUE: begin
                w_stateNext = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    w_loadPc    = 1'b1;
                    w_stateNext = REQ;
                end
            end
            ERROR: begin
                w_stateNext = ERROR;
            end
            default: begin
                w_stateNext = REQ;
            end
        endcase
    end

    // PC, instruction and exception-PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_VECTOR;
            r_instr <= '0;
`ifdef SECUENCIADOR_EXCEPCION_EN
            r_epc   <= '0;
`endif
        end else begin
            if (w_loadInstr)
                r_instr <= imem_rdata;
            if (w_loadPc) begin
                r_pc <= w_nextPc;
`ifdef SECUENCIADOR_EXCEPCION_EN
                if (excepcion)
                    r_epc <= r_pc;
`endif
            end
        end
    end

    // Outputs decoded from registered state only
    assign imem_req    = (r_state == REQ) && r_started;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == ISSUE);
    assign fetch_err   = (r_state == ERROR);
`ifdef SECUENCIADOR_EXCEPCION_EN
    assign epc         = r_epc;
`endif

endmodule : secuenciador_pc
`default_nettype wire

// File: tb/tb_secuenciador_pc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_secuenciador_pc
//  Description : Self-checking bench for secuenciador_pc. Fetched words are
//                pushed to a scoreboard when acked and popped on instr_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_secuenciador_pc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        salto_cond;
    logic        zero;
    logic [31:0] ext_signo;
    logic        salto_incond;
    logic [25:0] dest_salto;
    logic [31:0] pc;
    logic        fetch_err;
`ifdef SECUENCIADOR_EXCEPCION_EN
    logic        excepcion;
    logic [31:0] epc;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lastValid = -1;
    bit chkSpacing = 1'b0;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic [63:0] sb[$];

    secuenciador_pc #(
        .RESET_VECTOR  (32'h0000_0000),
`ifdef SECUENCIADOR_EXCEPCION_EN
        .EXC_VECTOR    (32'h0000_0180),
`endif
        .FETCH_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .salto_cond   (salto_cond),
        .zero         (zero),
        .ext_signo    (ext_signo),
        .salto_incond (salto_incond),
        .dest_salto   (dest_salto),
        .pc           (pc),
`ifdef SECUENCIADOR_EXCEPCION_EN
        .excepcion    (excepcion),
        .epc          (epc),
`endif
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every instr_valid pulse must match the oldest acked word
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", {31'b0, instr_valid}, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("sb_pc", pc, e[63:32]);
                chk("sb_instr", instr, e[31:0]);
            end
            if (chkSpacing && lastValid >= 0)
                chk("valid_period", 32'(cyc - lastValid), 32'd3);
            lastValid = cyc;
        end
    end

    // Wait for imem_req, hold ack off for 'delay' cycles, then return the word
    task automatic fetch(input int delay, input logic [31:0] word);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            chk("req_wait_timeout", {31'b0, imem_req}, 32'd1);
            return;
        end
        for (int i = 0; i < delay; i++) begin
            chk("req_hold", {31'b0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, expPc);
            @(negedge clk);
        end
        chk("req_at_ack", {31'b0, imem_req}, 32'd1);
        chk("addr_at_ack", imem_addr, expPc);
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb.push_back({expPc, word});
        expInstr = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        exec_done  = 1'b0;
    endtask

    // Called at the ISSUE cycle: step into EXEC, retire with given branch inputs
    task automatic execute(input logic sc, input logic z, input logic [31:0] ext,
                           input logic si, input logic [25:0] dest, input logic exc,
                           input logic [31:0] expNext);
        chk("valid_in_issue", {31'b0, instr_valid}, 32'd1);
        @(negedge clk);
        chk("valid_low_exec", {31'b0, instr_valid}, 32'd0);
        chk("req_low_exec", {31'b0, imem_req}, 32'd0);
        chk("pc_hold_exec", pc, expPc);
        exec_done    = 1'b1;
        salto_cond   = sc;
        zero         = z;
        ext_signo    = ext;
        salto_incond = si;
        dest_salto   = dest;
        imem_ack     = 1'b1;            // must be ignored outside REQ
        imem_rdata   = 32'hDEAD_BEEF;
`ifdef SECUENCIADOR_EXCEPCION_EN
        excepcion    = exc;
`else
        if (exc) ;
`endif
        @(negedge clk);
        exec_done    = 1'b0;
        salto_cond   = 1'b0;
        zero         = 1'b0;
        ext_signo    = '0;
        salto_incond = 1'b0;
        dest_salto   = '0;
        imem_ack     = 1'b0;
`ifdef SECUENCIADOR_EXCEPCION_EN
        excepcion    = 1'b0;
`endif
        chk("next_pc", pc, expNext);
        chk("instr_hold", instr, expInstr);
        expPc = expNext;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        salto_cond = 1'b0; zero = 1'b0; ext_signo = '0; salto_incond = 1'b0; dest_salto = '0;
`ifdef SECUENCIADOR_EXCEPCION_EN
        excepcion = 1'b0;
`endif
        expPc = 32'h0; expInstr = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
`ifdef SECUENCIADOR_EXCEPCION_EN
        chk("rst_epc", epc, 32'h0);
`endif
        rst_n = 1'b1;

        // Sequential fetch at full rate
        chkSpacing = 1'b1;
        fetch(0, 32'h1111_0000); execute(0, 0, 0, 0, 0, 0, 32'h0000_0004);
        fetch(0, 32'h1111_0004); execute(0, 0, 0, 0, 0, 0, 32'h0000_0008);
        // Taken branch backwards: 0xC + (-2 << 2) = 0x4
        fetch(0, 32'h2222_0008); execute(1, 1, 32'hFFFF_FFFE, 0, 0, 0, 32'h0000_0004);
        fetch(0, 32'h1111_0004); execute(0, 0, 0, 0, 0, 0, 32'h0000_0008);
        // Branch not taken (zero=0)
        fetch(0, 32'h2222_0008); execute(1, 0, 32'hFFFF_FFFE, 0, 0, 0, 32'h0000_000C);
        // Large forward branch: 0x10 + 0x1000_0000
        fetch(0, 32'h3333_000C); execute(1, 1, 32'h0400_0000, 0, 0, 0, 32'h1000_0010);
        // Jump wins over a simultaneously taken branch
        fetch(0, 32'h4444_0010); execute(1, 1, 32'h0000_0005, 1, 26'h40, 0, 32'h1000_0100);
        chkSpacing = 1'b0;

        // Delayed ack with exec_done held high (ignored outside EXEC)
        exec_done = 1'b1;
        fetch(3, 32'h5555_0100);
        // Branch to the top word: 0x1000_0104 + 0xEFFF_FEF8 = 0xFFFF_FFFC
        execute(1, 1, 32'h3BFF_FFBE, 0, 0, 0, 32'hFFFF_FFFC);
        // Sequential wrap-around
        fetch(0, 32'h6666_FFFC); execute(0, 0, 0, 0, 0, 0, 32'h0000_0000);
        fetch(0, 32'h7777_0000); execute(0, 0, 0, 0, 0, 0, 32'h0000_0004);

        // Reset during EXEC with exec_done and a jump pending
        fetch(0, 32'h7777_0004);
        @(negedge clk);
        rst_n = 1'b0; exec_done = 1'b1; salto_incond = 1'b1; dest_salto = 26'h3FF_FFFF;
        @(negedge clk);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_instr", instr, 32'h0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_pc", pc, 32'h0);
            chk("postrst_req", {31'b0, imem_req}, 32'd1);
        end
        exec_done = 1'b0; salto_incond = 1'b0; dest_salto = '0;
        expPc = 32'h0; expInstr = 32'h0;

        // Jump to 0x24, then exercise the exception path there
        fetch(0, 32'h8888_0000); execute(0, 0, 0, 1, 26'h9, 0, 32'h0000_0024);
`ifdef SECUENCIADOR_EXCEPCION_EN
        excepcion = 1'b1;               // ignored while fetching
        fetch(0, 32'h9999_0024);
        excepcion = 1'b0;
        execute(0, 0, 0, 1, 26'h3FF, 1, 32'h0000_0180);
        chk("exc_epc", epc, 32'h0000_0024);
`else
        fetch(0, 32'h9999_0024);
        execute(0, 0, 0, 1, 26'h3FF, 1, 32'h0000_0FFC);
`endif

        // Fetch timeout: no ack at all
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            chk("to_addr", imem_addr, expPc);
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", 32'(n), 32'd8);
        chk("to_err", {31'b0, fetch_err}, 32'd1);
        chk("to_req_low", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; exec_done = 1'b1;
        repeat (4) @(negedge clk);
        chk("to_err_sticky", {31'b0, fetch_err}, 32'd1);
        chk("to_valid_low", {31'b0, instr_valid}, 32'd0);
        chk("to_pc_hold", pc, expPc);
        imem_ack = 1'b0; exec_done = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("to_err_cleared", {31'b0, fetch_err}, 32'd0);
        chk("to_rst_pc", pc, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_secuenciador_pc
`default_nettype wire
